// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port backing memory between the instruction-fetch (IF)
//   port and the MEM-stage data (DM) port. Each access runs IDLE -> BUSY -> RESP:
//   the grant latches the owner and the memory command, BUSY waits for
//   mem_ack_i, and RESP pulses the owner's ack for one cycle. Contended
//   requests alternate round-robin. A watchdog ends a hung access after
//   TIMEOUT BUSY cycles with a zero data word and an err_o pulse.
//
// Ports
//   clk_i, rst_i (async, active-low)
//   if_req_i/if_addr_i -> if_ack_o/if_rdata_o           fetch port
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i
//                      -> dm_ack_o/dm_rdata_o           data port
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o
//                      <- mem_ack_i/mem_rdata_i         backing memory
//   stall_o  combinational: any requester still waiting for its ack
//   err_o    pulse alongside an ack that ended by timeout
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT != 0);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_owner_dm;  // 1: current transaction belongs to DM
  logic              r_last_dm;   // 1: most recent grant went to DM
  logic [WDOG_W-1:0] r_wdog;

  logic w_any_req;
  logic w_grant_dm;
  logic w_timeout;

  assign w_any_req  = if_req_i | dm_req_i;
  // DM wins when alone, or on contention when IF was served last.
  assign w_grant_dm = dm_req_i & (~if_req_i | ~r_last_dm);
  assign w_timeout  = WDOG_EN && (r_wdog == WDOG_LAST);

  assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

  // Transaction sequencer: grant, memory command, watchdog and responses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_owner_dm  <= 1'b0;
      r_last_dm   <= 1'b0;
      r_wdog      <= '0;
      if_ack_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      err_o       <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      // Response strobes are single-cycle; RESP is the only state that sees them high.
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      err_o    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner_dm  <= w_grant_dm;
            r_last_dm   <= w_grant_dm;
            r_wdog      <= '0;
            mem_en_o    <= 1'b1;
            mem_we_o    <= w_grant_dm & dm_we_i;
            mem_addr_o  <= w_grant_dm ? dm_addr_i : if_addr_i;
            mem_wdata_o <= w_grant_dm ? dm_wdata_i : {DATA_W{1'b0}};
            r_state     <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          r_wdog <= r_wdog + WDOG_W'(1);
          // An ack arriving on the last watchdog cycle still counts as a normal ack.
          if (mem_ack_i) begin
            if (r_owner_dm) begin
              if (!mem_we_o) begin
                dm_rdata_o <= mem_rdata_i;
              end else begin
                dm_rdata_o <= dm_rdata_o;
              end
              dm_ack_o <= 1'b1;
            end else begin
              if_rdata_o <= mem_rdata_i;
              if_ack_o   <= 1'b1;
            end
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            r_state  <= ST_RESP;
          end else if (w_timeout) begin
            if (r_owner_dm) begin
              dm_rdata_o <= '0;
              dm_ack_o   <= 1'b1;
            end else begin
              if_rdata_o <= '0;
              if_ack_o   <= 1'b1;
            end
            err_o    <= 1'b1;
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            r_state  <= ST_RESP;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          mem_en_o <= 1'b0;
          mem_we_o <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = 32'h0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    tick(); tick();
    check("rst_mem_en", {31'd0, mem_en_o}, 32'd0);
    check("rst_acks", {30'd0, if_ack_o, dm_ack_o}, 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'h0);
    check("rst_dm_rdata", dm_rdata_o, 32'h0);
    check("rst_err_stall", {30'd0, err_o, stall_o}, 32'd0);
    rst_i = 1'b1;
    tick();

    // 1: lone IF read, memory acks on the third BUSY cycle
    if_req_i = 1'b1; if_addr_i = 32'h40;
    #1 check("t1_stall_req", {31'd0, stall_o}, 32'd1);
    tick();  // BUSY 1
    check("t1_mem_en", {31'd0, mem_en_o}, 32'd1);
    check("t1_mem_addr", mem_addr_o, 32'h40);
    check("t1_mem_we", {31'd0, mem_we_o}, 32'd0);
    tick();  // BUSY 2
    check("t1_no_early_ack", {31'd0, if_ack_o}, 32'd0);
    tick();  // BUSY 3
    mem_ack_i = 1'b1; mem_rdata_i = 32'h00A00093;
    #1 check("t1_stall_busy", {31'd0, stall_o}, 32'd1);
    tick();  // RESP
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    check("t1_if_ack", {30'd0, if_ack_o, dm_ack_o}, 32'd2);
    check("t1_if_rdata", if_rdata_o, 32'h00A00093);
    check("t1_stall_ack", {31'd0, stall_o}, 32'd0);
    check("t1_mem_en_resp", {31'd0, mem_en_o}, 32'd0);
    if_req_i = 1'b0;
    tick();  // IDLE
    check("t1_ack_single", {31'd0, if_ack_o}, 32'd0);
    check("t1_rdata_held", if_rdata_o, 32'h00A00093);

    // 2: first contention after reset goes to DM
    if_req_i = 1'b1; if_addr_i = 32'h44;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20;
    tick();  // BUSY (DM)
    check("t2_dm_first", mem_addr_o, 32'h20);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
    tick();  // RESP
    mem_ack_i = 1'b0;
    check("t2_dm_ack", {30'd0, if_ack_o, dm_ack_o}, 32'd1);
    check("t2_dm_rdata", dm_rdata_o, 32'h11111111);
    check("t2_stall_if_wait", {31'd0, stall_o}, 32'd1);
    dm_req_i = 1'b0;
    tick();  // IDLE: DM re-requests while IF still waits -> IF (not last grant)
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h10; dm_wdata_i = 32'hDEADBEEF;
    tick();  // BUSY (IF)
    check("t2_if_on_contention", mem_addr_o, 32'h44);
    check("t2_if_we0", {31'd0, mem_we_o}, 32'd0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222;
    tick();  // RESP
    mem_ack_i = 1'b0;
    check("t2_if_ack", {30'd0, if_ack_o, dm_ack_o}, 32'd2);
    check("t2_if_rdata", if_rdata_o, 32'h22222222);
    if_req_i = 1'b0;
    tick();  // IDLE: DM write granted

    // 3: DM write held stable through BUSY
    tick();  // BUSY 1
    check("t3_we", {31'd0, mem_we_o}, 32'd1);
    check("t3_addr", mem_addr_o, 32'h10);
    check("t3_wdata", mem_wdata_o, 32'hDEADBEEF);
    dm_addr_i = 32'h0; dm_wdata_i = 32'h0;  // mid-transaction changes are ignored
    tick();  // BUSY 2
    check("t3_addr_stable", mem_addr_o, 32'h10);
    check("t3_wdata_stable", mem_wdata_o, 32'hDEADBEEF);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
    tick();  // RESP
    mem_ack_i = 1'b0;
    check("t3_dm_ack", {31'd0, dm_ack_o}, 32'd1);
    check("t3_rdata_kept", dm_rdata_o, 32'h11111111);
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    tick();  // IDLE

    // 4: IF access that never acks -> 4 BUSY cycles then error response
    if_req_i = 1'b1; if_addr_i = 32'h80;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t4_busy", {30'd0, mem_en_o, if_ack_o}, 32'd2);
      tick();
    end
    check("t4_ack_err", {29'd0, if_ack_o, err_o, mem_en_o}, 32'd6);
    check("t4_rdata_zero", if_rdata_o, 32'h0);
    if_req_i = 1'b0;
    tick();
    check("t4_idle", {29'd0, if_ack_o, err_o, mem_en_o}, 32'd0);

    // 5: ack on the last watchdog cycle is a normal ack; stray ack in IDLE ignored
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h30;
    tick(); tick(); tick(); tick();  // BUSY wdog 3
    check("t5_still_busy", {31'd0, mem_en_o}, 32'd1);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    tick();
    mem_ack_i = 1'b0;
    check("t5_ack_no_err", {30'd0, dm_ack_o, err_o}, 32'd2);
    check("t5_rdata", dm_rdata_o, 32'hCAFEF00D);
    dm_req_i = 1'b0;
    tick();  // IDLE
    mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    tick(); tick();
    check("t5_stray_ctrl", {28'd0, mem_en_o, if_ack_o, dm_ack_o, err_o}, 32'd0);
    check("t5_stray_dm", dm_rdata_o, 32'hCAFEF00D);
    check("t5_stray_if", if_rdata_o, 32'h0);
    mem_ack_i = 1'b0;

    // 6: reset asserted mid-transaction
    if_req_i = 1'b1; if_addr_i = 32'h90;
    tick();
    check("t6_busy", {31'd0, mem_en_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1 check("t6_async_drop", {29'd0, mem_en_o, if_ack_o, dm_ack_o}, 32'd0);
    check("t6_rdata_reset", dm_rdata_o, 32'h0);
    if_req_i = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'hA0;
    dm_req_i = 1'b1; dm_addr_i = 32'hB0;
    tick();
    check("t6_dm_after_reset", mem_addr_o, 32'hB0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
    tick();
    mem_ack_i = 1'b0;
    check("t6_dm_ack", {30'd0, if_ack_o, dm_ack_o}, 32'd1);
    dm_req_i = 1'b0; if_req_i = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
